// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS stream packer and related stream IPs.
package dds_pkg;
  localparam int SAMPLE_W = 16;
  localparam int AXIS_W   = 32;

  typedef enum logic {LOW = 1'b0, HIGH = 1'b1} pair_state_e;
  typedef logic [AXIS_W-1:0] axis_word_t;

  // Earlier sample occupies the low half of the beat.
  function automatic axis_word_t pack_pair(input logic [SAMPLE_W-1:0] lo,
                                           input logic [SAMPLE_W-1:0] hi);
    return {hi, lo};
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational read of the head entry (first-word-fall-through).
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == DEPTH_V);
  assign empty = (count == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/dds_stream_packer.sv
// Packs pairs of 16-bit DDS samples into 32-bit AXI4-Stream beats with periodic TLAST,
// buffering through a FIFO and flagging words lost to downstream backpressure.
module dds_stream_packer
  import dds_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = 16
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESET,
  input  logic [SAMPLE_W-1:0]           in_sample,
  input  logic                          in_valid,
  input  logic                          enable,
  input  logic [LEN_W-1:0]              pkt_len,
  input  logic                          overflow_clr,
  output logic [AXIS_W-1:0]             M_AXIS_TDATA,
  output logic                          M_AXIS_TVALID,
  input  logic                          M_AXIS_TREADY,
  output logic                          M_AXIS_TLAST,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_V = CNT_W'(FIFO_DEPTH);

  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
    return (len == '0) ? LEN_W'(1) : len;
  endfunction

  pair_state_e         state;
  pair_state_e         state_nxt;
  logic [SAMPLE_W-1:0] low_q;
  logic                latch_low;
  logic                push_req;
  axis_word_t          push_word;

  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  axis_word_t          fifo_rdata;
  logic [CNT_W-1:0]    fifo_count;
  logic                room;
  logic                drop;

  logic                out_valid;
  axis_word_t          out_data;
  logic                out_last;
  logic                load;
  logic [LEN_W-1:0]    beat_cnt;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    len_cur;
  logic                beat_last;

  // Stage: sample pairing
  always_comb begin
    state_nxt = state;
    latch_low = 1'b0;
    push_req  = 1'b0;
    push_word = pack_pair(low_q, in_sample);
    if (!enable) begin
      state_nxt = LOW;
    end else if (in_valid) begin
      case (state)
        LOW: begin
          latch_low = 1'b1;
          state_nxt = HIGH;
        end
        HIGH: begin
          push_req  = 1'b1;
          state_nxt = LOW;
        end
        default: state_nxt = LOW;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) state <= LOW;
    else              state <= state_nxt;
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (latch_low) low_q <= in_sample;
  end

  // Stage: FIFO admission; room is judged before any same-cycle pop
  assign fill_level = fifo_count + CNT_W'(out_valid);
  assign room       = (fill_level < DEPTH_V) && !fifo_full;
  assign fifo_push  = push_req && room;
  assign drop       = push_req && !room;

  sync_fifo #(
    .WIDTH (AXIS_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (S_AXI_ACLK),
    .rst   (S_AXI_ARESET),
    .push  (fifo_push),
    .wdata (push_word),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET)      overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (overflow_clr) overflow <= 1'b0;
  end

  // Stage: output register; beat_cnt indexes the beat being loaded within its packet
  assign load      = !fifo_empty && (!out_valid || M_AXIS_TREADY);
  assign fifo_pop  = load;
  assign len_cur   = (beat_cnt == '0) ? eff_len(pkt_len) : len_q;
  assign beat_last = (beat_cnt == len_cur - LEN_W'(1));

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      beat_cnt  <= '0;
      len_q     <= LEN_W'(1);
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= fifo_rdata;
      out_last  <= beat_last;
      beat_cnt  <= beat_last ? '0 : beat_cnt + 1'b1;
      if (beat_cnt == '0) len_q <= len_cur;
    end else if (M_AXIS_TREADY) begin
      out_valid <= 1'b0;
    end
  end

  assign M_AXIS_TDATA  = out_data;
  assign M_AXIS_TVALID = out_valid;
  assign M_AXIS_TLAST  = out_last;
endmodule

// File: tb/tb_dds_stream_packer.sv
// Directed and randomized-backpressure bench for dds_stream_packer.
module tb_dds_stream_packer;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_sample;
  logic        in_valid;
  logic        enable;
  logic [15:0] pkt_len;
  logic        overflow_clr;
  logic        tready;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        overflow;
  logic [4:0]  fill_level;

  int checks   = 0;
  int failures = 0;
  logic [32:0] beats[$];

  always #5 clk = ~clk;

  dds_stream_packer #(.FIFO_DEPTH(16), .LEN_W(16)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESET  (rst),
    .in_sample     (in_sample),
    .in_valid      (in_valid),
    .enable        (enable),
    .pkt_len       (pkt_len),
    .overflow_clr  (overflow_clr),
    .M_AXIS_TDATA  (tdata),
    .M_AXIS_TVALID (tvalid),
    .M_AXIS_TREADY (tready),
    .M_AXIS_TLAST  (tlast),
    .overflow      (overflow),
    .fill_level    (fill_level)
  );

  // Record every handshake that the next rising edge will complete.
  always @(negedge clk) begin
    if (!rst && tvalid && tready) beats.push_back({tlast, tdata});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sample(input logic [15:0] s);
    in_sample = s;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_sample    = 16'h0;
    enable       = 1'b1;
    overflow_clr = 1'b0;
    tready       = 1'b1;
    tick();
    tick();
    beats.delete();
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    tready = 1'b1;
    while ((tvalid || fill_level != 0) && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL %s_drain: still valid=%0b fill=%0d after 200 cycles, required empty", name, tvalid, fill_level);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks += 5;
    if (tvalid !== 1'b0)     begin failures++; $display("FAIL reset_tvalid: got %0b want 0", tvalid); end
    if (tlast !== 1'b0)      begin failures++; $display("FAIL reset_tlast: got %0b want 0", tlast); end
    if (tdata !== 32'h0)     begin failures++; $display("FAIL reset_tdata: got %h want 0", tdata); end
    if (overflow !== 1'b0)   begin failures++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
    if (fill_level !== 5'd0) begin failures++; $display("FAIL reset_fill: got %0d want 0", fill_level); end
    // Reset in the middle of a packet with queued words
    pkt_len = 16'd2;
    tready  = 1'b0;
    for (int k = 0; k < 6; k++) send_sample(16'h0700 + 16'(k));
    send_sample(16'h0799);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks += 3;
    if (tvalid !== 1'b0)     begin failures++; $display("FAIL midreset_tvalid: got %0b want 0", tvalid); end
    if (fill_level !== 5'd0) begin failures++; $display("FAIL midreset_fill: got %0d want 0", fill_level); end
    if (tdata !== 32'h0)     begin failures++; $display("FAIL midreset_tdata: got %h want 0", tdata); end
    beats.delete();
    tready = 1'b1;
    send_sample(16'h00A1);
    send_sample(16'h00B2);
    drain("midreset");
    checks++;
    if (beats.size() != 1 || beats[0] !== {1'b0, 32'h00B200A1})
      begin failures++; $display("FAIL midreset_beat: got n=%0d first=%h want n=1 0_00b200a1", beats.size(), beats.size() > 0 ? beats[0] : 33'h0); end
  endtask

  task automatic test_basic();
    do_reset();
    pkt_len = 16'd2;
    send_sample(16'h0001);
    send_sample(16'h0002);
    checks++;
    if (tvalid !== 1'b0) begin failures++; $display("FAIL basic_early_valid: got %0b want 0", tvalid); end
    send_sample(16'h0003);
    checks += 3;
    if (tvalid !== 1'b1)        begin failures++; $display("FAIL basic_first_valid: got %0b want 1", tvalid); end
    if (tdata !== 32'h00020001) begin failures++; $display("FAIL basic_first_data: got %h want 00020001", tdata); end
    if (tlast !== 1'b0)         begin failures++; $display("FAIL basic_first_last: got %0b want 0", tlast); end
    send_sample(16'h0004);
    drain("basic");
    checks += 3;
    if (beats.size() != 2) begin failures++; $display("FAIL basic_count: got %0d want 2", beats.size()); end
    if (beats.size() > 0 && beats[0] !== {1'b0, 32'h00020001})
      begin failures++; $display("FAIL basic_beat0: got %h want 0_00020001", beats[0]); end
    if (beats.size() > 1 && beats[1] !== {1'b1, 32'h00040003})
      begin failures++; $display("FAIL basic_beat1: got %h want 1_00040003", beats[1]); end
  endtask

  task automatic test_overflow();
    logic [31:0] exp;
    do_reset();
    pkt_len = 16'd1;
    tready  = 1'b0;
    for (int j = 0; j < 17; j++) begin
      if (j == 16) begin
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_early: got %0b want 0", overflow); end
      end
      send_sample(16'h1000 + 16'(2*j));
      send_sample(16'h1000 + 16'(2*j+1));
    end
    tick();
    checks += 2;
    if (fill_level !== 5'd16) begin failures++; $display("FAIL ovf_fill: got %0d want 16", fill_level); end
    if (overflow !== 1'b1)    begin failures++; $display("FAIL ovf_flag: got %0b want 1", overflow); end
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear: got %0b want 0", overflow); end
    send_sample(16'h5555);
    overflow_clr = 1'b1;
    send_sample(16'h6666);
    overflow_clr = 1'b0;
    checks += 2;
    if (overflow !== 1'b1)    begin failures++; $display("FAIL ovf_clr_vs_drop: got %0b want 1", overflow); end
    if (fill_level !== 5'd16) begin failures++; $display("FAIL ovf_fill_hold: got %0d want 16", fill_level); end
    drain("ovf");
    checks++;
    if (beats.size() != 16) begin failures++; $display("FAIL ovf_count: got %0d want 16", beats.size()); end
    for (int j = 0; j < 16 && j < beats.size(); j++) begin
      exp = {16'h1000 + 16'(2*j+1), 16'h1000 + 16'(2*j)};
      checks++;
      if (beats[j][31:0] !== exp) begin failures++; $display("FAIL ovf_word%0d: got %h want %h", j, beats[j][31:0], exp); end
    end
  endtask

  task automatic test_enable();
    do_reset();
    pkt_len = 16'd1;
    send_sample(16'hAAAA);
    enable    = 1'b0;
    in_sample = 16'hBBBB;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    enable    = 1'b1;
    send_sample(16'h1111);
    send_sample(16'h2222);
    drain("enable");
    checks += 2;
    if (beats.size() != 1) begin failures++; $display("FAIL enable_count: got %0d want 1", beats.size()); end
    if (beats.size() > 0 && beats[0] !== {1'b1, 32'h22221111})
      begin failures++; $display("FAIL enable_beat: got %h want 1_22221111", beats[0]); end
  endtask

  task automatic test_packet();
    logic        exp_last [11];
    logic [31:0] exp;
    exp_last = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    pkt_len = 16'd3;
    for (int j = 0; j < 8; j++) begin
      send_sample(16'h2000 + 16'(2*j));
      send_sample(16'h2000 + 16'(2*j+1));
      if (beats.size() >= 1) pkt_len = 16'd5;
    end
    drain("pkt_a");
    pkt_len = 16'd0;
    for (int j = 8; j < 11; j++) begin
      send_sample(16'h2000 + 16'(2*j));
      send_sample(16'h2000 + 16'(2*j+1));
    end
    drain("pkt_b");
    checks++;
    if (beats.size() != 11) begin failures++; $display("FAIL pkt_count: got %0d want 11", beats.size()); end
    for (int j = 0; j < 11 && j < beats.size(); j++) begin
      exp = {16'h2000 + 16'(2*j+1), 16'h2000 + 16'(2*j)};
      checks++;
      if (beats[j] !== {exp_last[j], exp})
        begin failures++; $display("FAIL pkt_beat%0d: got %h want %h", j, beats[j], {exp_last[j], exp}); end
    end
  endtask

  task automatic test_back_to_back();
    int          sent = 0;
    int          cycles = 0;
    int          nlast = 0;
    int          bad = 0;
    logic        pv, pr, pl;
    logic [31:0] pd;
    logic [31:0] exp;
    do_reset();
    pkt_len = 16'd4;
    while (sent < 1000 && cycles < 20000) begin
      tready    = ($urandom_range(0, 9) < 7);
      in_valid  = $urandom_range(0, 1) == 1;
      in_sample = 16'(sent);
      pv = tvalid; pr = tready; pd = tdata; pl = tlast;
      tick();
      if (in_valid) sent++;
      cycles++;
      if (pv && !pr) begin
        checks++;
        if (tvalid !== 1'b1 || tdata !== pd || tlast !== pl) begin
          failures++;
          $display("FAIL stall_stable: got v=%0b d=%h l=%0b want v=1 d=%h l=%0b", tvalid, tdata, tlast, pd, pl);
        end
      end
    end
    in_valid = 1'b0;
    drain("rand");
    checks += 2;
    if (overflow !== 1'b0)   begin failures++; $display("FAIL rand_overflow: got %0b want 0", overflow); end
    if (beats.size() != 500) begin failures++; $display("FAIL rand_count: got %0d want 500", beats.size()); end
    for (int i = 0; i < beats.size(); i++) begin
      exp = {16'(2*i+1), 16'(2*i)};
      if (beats[i][31:0] !== exp || beats[i][32] !== ((i % 4) == 3)) begin
        if (bad < 5) $display("FAIL rand_beat%0d: got %h want %0b_%h", i, beats[i], (i % 4) == 3, exp);
        bad++;
      end
      if (beats[i][32]) nlast++;
    end
    checks += 2;
    if (bad != 0)     begin failures++; $display("FAIL rand_order: %0d beats wrong, required 0", bad); end
    if (nlast != 125) begin failures++; $display("FAIL rand_tlast_count: got %0d want 125", nlast); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sample = 16'h0; enable = 1'b0;
    pkt_len = 16'd1; overflow_clr = 1'b0; tready = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_enable();
    test_packet();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
